// File: rtl/mr_pkg.sv
// mr_pkg: shared definitions for the MazeRunner command path.
//   state_t         dispatcher FSM states
//   OP_CAL/HDG/MV   legal command opcodes (cmd[15:12])
//   ACK_DEF/NAK_DEF default response bytes returned to the host
package mr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CAL,
        WAIT_HDG,
        WAIT_MV,
        TX_ACK,
        TX_TLM
    } state_t;

    localparam logic [3:0] OP_CAL = 4'h0;
    localparam logic [3:0] OP_HDG = 4'h2;
    localparam logic [3:0] OP_MV  = 4'h4;

    localparam logic [7:0] ACK_DEF = 8'hA5;
    localparam logic [7:0] NAK_DEF = 8'hEE;

endpackage

// File: rtl/cmd_tmo_cnt.sv
// cmd_tmo_cnt: clearable, saturating completion-timeout counter.
//   i_clk, i_rst_n  clock / asynchronous active-low reset
//   i_clr           synchronous clear to zero (priority over i_en)
//   i_en            count one waiting cycle
//   o_sat           high while the current cycle is the last waiting cycle
//                   before saturation (or the counter is already saturated)
module cmd_tmo_cnt #(
    parameter int unsigned W = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_sat
);

    localparam logic [W-1:0] C_MAX  = '1;
    localparam logic [W-1:0] C_LAST = C_MAX - W'(1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != C_MAX)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // The count reads zero in the first waiting cycle, so flagging one count
    // early lets the FSM act on the edge that closes waiting cycle 2^W-1.
    assign o_sat = (r_cnt >= C_LAST);

endmodule

// File: rtl/cmd_dispatch.sv
// cmd_dispatch: command dispatcher and UART-TX arbiter.
//   clk, rst_n            clock / asynchronous active-low reset
//   cmd, cmd_rdy          assembled command and its level-valid flag
//   clr_cmd_rdy           one-cycle pulse consuming the command
//   cal_go/cal_done       calibration start / completion
//   hdg_go/hdg_done       heading start / completion, heading = target
//   mv_go/mv_done         move start / completion, mv_sq = squares
//   trmt, tx_data,tx_done UART TX launch, byte (held until done), finish
//   tlm_req/tlm_data      telemetry request (held) and byte
//   tlm_gnt               telemetry grant, coincident with trmt
//   busy                  high outside IDLE
//   err                   sticky NAK indicator
module cmd_dispatch
    import mr_pkg::*;
#(
    parameter logic [7:0]  ACK_BYTE = ACK_DEF,
    parameter logic [7:0]  NAK_BYTE = NAK_DEF,
    parameter int unsigned TMO_W    = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        cal_go,
    input  logic        cal_done,
    output logic        hdg_go,
    input  logic        hdg_done,
    output logic [11:0] heading,
    output logic        mv_go,
    input  logic        mv_done,
    output logic [2:0]  mv_sq,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    input  logic        tlm_req,
    input  logic [7:0]  tlm_data,
    output logic        tlm_gnt,
    output logic        busy,
    output logic        err
);

    state_t     r_state;
    logic       w_waiting;
    logic       w_done_sel;
    logic       w_tmo_clr;
    logic       w_tmo;
    logic [3:0] w_op;

    assign w_op = cmd[15:12];

    // Completion from the unit being waited on; other units' done is ignored.
    always_comb begin
        w_waiting  = 1'b0;
        w_done_sel = 1'b0;
        case (r_state)
            WAIT_CAL: begin w_waiting = 1'b1; w_done_sel = cal_done; end
            WAIT_HDG: begin w_waiting = 1'b1; w_done_sel = hdg_done; end
            WAIT_MV:  begin w_waiting = 1'b1; w_done_sel = mv_done;  end
            default:  ;
        endcase
    end

    // Held clear outside the WAIT states, so every wait starts from zero.
    assign w_tmo_clr = !w_waiting;

    cmd_tmo_cnt #(.W(TMO_W)) u_tmo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (w_tmo_clr),
        .i_en    (w_waiting),
        .o_sat   (w_tmo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            clr_cmd_rdy <= 1'b0;
            cal_go      <= 1'b0;
            hdg_go      <= 1'b0;
            mv_go       <= 1'b0;
            heading     <= '0;
            mv_sq       <= '0;
            trmt        <= 1'b0;
            tx_data     <= '0;
            tlm_gnt     <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            clr_cmd_rdy <= 1'b0;
            cal_go      <= 1'b0;
            hdg_go      <= 1'b0;
            mv_go       <= 1'b0;
            trmt        <= 1'b0;
            tlm_gnt     <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Commands take priority over telemetry.
                    if (cmd_rdy) begin
                        clr_cmd_rdy <= 1'b1;
                        busy        <= 1'b1;
                        case (w_op)
                            OP_CAL: begin
                                cal_go  <= 1'b1;
                                r_state <= WAIT_CAL;
                            end
                            OP_HDG: begin
                                hdg_go  <= 1'b1;
                                heading <= cmd[11:0];
                                r_state <= WAIT_HDG;
                            end
                            OP_MV: begin
                                mv_go   <= 1'b1;
                                mv_sq   <= cmd[2:0];
                                r_state <= WAIT_MV;
                            end
                            default: begin
                                trmt    <= 1'b1;
                                tx_data <= NAK_BYTE;
                                err     <= 1'b1;
                                r_state <= TX_ACK;
                            end
                        endcase
                    end else if (tlm_req) begin
                        tlm_gnt <= 1'b1;
                        trmt    <= 1'b1;
                        tx_data <= tlm_data;
                        busy    <= 1'b1;
                        r_state <= TX_TLM;
                    end
                end
                WAIT_CAL, WAIT_HDG, WAIT_MV: begin
                    // Done is checked first so it wins a tie with the timeout.
                    if (w_done_sel) begin
                        trmt    <= 1'b1;
                        tx_data <= ACK_BYTE;
                        r_state <= TX_ACK;
                    end else if (w_tmo) begin
                        trmt    <= 1'b1;
                        tx_data <= NAK_BYTE;
                        err     <= 1'b1;
                        r_state <= TX_ACK;
                    end
                end
                TX_ACK, TX_TLM: begin
                    if (tx_done) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch: directed scenarios plus randomized traffic against a
// transaction-level model of the dispatcher.
module tb_cmd_dispatch;

    localparam int TMO_W     = 4;
    localparam int TMO_LIMIT = (1 << TMO_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        cal_go, cal_done;
    logic        hdg_go, hdg_done;
    logic [11:0] heading;
    logic        mv_go, mv_done;
    logic [2:0]  mv_sq;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        tlm_req;
    logic [7:0]  tlm_data;
    logic        tlm_gnt;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    cmd_dispatch #(.TMO_W(TMO_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cal_go      (cal_go),
        .cal_done    (cal_done),
        .hdg_go      (hdg_go),
        .hdg_done    (hdg_done),
        .heading     (heading),
        .mv_go       (mv_go),
        .mv_done     (mv_done),
        .mv_sq       (mv_sq),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .tlm_req     (tlm_req),
        .tlm_data    (tlm_data),
        .tlm_gnt     (tlm_gnt),
        .busy        (busy),
        .err         (err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase: 0 idle, 1 waiting on unit m_unit, 2 sending a byte
    int         m_phase, m_unit, m_elapsed;
    logic       e_clr, e_cal, e_hdg, e_mv, e_trmt, e_gnt, e_busy, e_err;
    logic [11:0] e_head;
    logic [2:0]  e_sq;
    logic [7:0]  e_tx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_unit <= 0; m_elapsed <= 0;
            e_clr <= 0; e_cal <= 0; e_hdg <= 0; e_mv <= 0;
            e_trmt <= 0; e_gnt <= 0; e_busy <= 0; e_err <= 0;
            e_head <= 0; e_sq <= 0; e_tx <= 0;
        end else begin
            e_clr <= 0; e_cal <= 0; e_hdg <= 0; e_mv <= 0; e_trmt <= 0; e_gnt <= 0;
            if (m_phase == 0) begin
                if (cmd_rdy) begin
                    e_clr  <= 1;
                    e_busy <= 1;
                    m_elapsed <= 0;
                    if (cmd[15:12] == 4'h0) begin
                        e_cal <= 1; m_unit <= 0; m_phase <= 1;
                    end else if (cmd[15:12] == 4'h2) begin
                        e_hdg <= 1; e_head <= cmd[11:0]; m_unit <= 1; m_phase <= 1;
                    end else if (cmd[15:12] == 4'h4) begin
                        e_mv <= 1; e_sq <= cmd[2:0]; m_unit <= 2; m_phase <= 1;
                    end else begin
                        e_trmt <= 1; e_tx <= 8'hEE; e_err <= 1; m_phase <= 2;
                    end
                end else if (tlm_req) begin
                    e_gnt <= 1; e_trmt <= 1; e_tx <= tlm_data; e_busy <= 1; m_phase <= 2;
                end
            end else if (m_phase == 1) begin
                if ((m_unit == 0 && cal_done) || (m_unit == 1 && hdg_done) ||
                    (m_unit == 2 && mv_done)) begin
                    e_trmt <= 1; e_tx <= 8'hA5; m_phase <= 2;
                end else if (m_elapsed + 1 == TMO_LIMIT) begin
                    e_trmt <= 1; e_tx <= 8'hEE; e_err <= 1; m_phase <= 2;
                end else begin
                    m_elapsed <= m_elapsed + 1;
                end
            end else if (tx_done) begin
                m_phase <= 0; e_busy <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("clr_cmd_rdy", clr_cmd_rdy, e_clr);
            chk("cal_go", cal_go, e_cal);
            chk("hdg_go", hdg_go, e_hdg);
            chk("mv_go", mv_go, e_mv);
            chk("trmt", trmt, e_trmt);
            chk("tlm_gnt", tlm_gnt, e_gnt);
            chk("busy", busy, e_busy);
            chk("err", err, e_err);
            chk("heading", heading, e_head);
            chk("mv_sq", mv_sq, e_sq);
            chk("tx_data", tx_data, e_tx);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] c);
        cmd = c;
        cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
    endtask

    task automatic pulse_done(input int u);
        cal_done = (u == 0);
        hdg_done = (u == 1);
        mv_done  = (u == 2);
        tick();
        cal_done = 0; hdg_done = 0; mv_done = 0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        int n;
        int r;
        logic [3:0] op;

        rst_n = 0; cmd = 0; cmd_rdy = 0; cal_done = 0; hdg_done = 0; mv_done = 0;
        tx_done = 0; tlm_req = 0; tlm_data = 0;
        tick(); tick();
        cmp_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_trmt", trmt, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_heading", heading, 0);
        rst_n = 1;
        tick();

        // heading command
        send_cmd(16'h23FF);
        chk("hdg_clr", clr_cmd_rdy, 1);
        chk("hdg_go", hdg_go, 1);
        chk("hdg_heading", heading, 12'h3FF);
        chk("hdg_busy", busy, 1);
        repeat (3) tick();
        chk("hdg_go_one_cycle", hdg_go, 0);
        pulse_done(1);
        chk("hdg_ack_trmt", trmt, 1);
        chk("hdg_ack_byte", tx_data, 8'hA5);
        tick();
        chk("hdg_tx_held", tx_data, 8'hA5);
        pulse_tx_done();
        chk("hdg_idle_busy", busy, 0);

        // move command, foreign done ignored
        send_cmd(16'h4005);
        chk("mv_go", mv_go, 1);
        chk("mv_sq", mv_sq, 3'd5);
        tick();
        pulse_done(0);
        chk("mv_ignore_cal", trmt, 0);
        chk("mv_still_busy", busy, 1);
        pulse_done(2);
        chk("mv_ack_trmt", trmt, 1);
        chk("mv_ack_byte", tx_data, 8'hA5);
        pulse_tx_done();

        // illegal opcode
        send_cmd(16'h7000);
        chk("ill_clr", clr_cmd_rdy, 1);
        chk("ill_trmt", trmt, 1);
        chk("ill_byte", tx_data, 8'hEE);
        chk("ill_no_go", {cal_go, hdg_go, mv_go}, 0);
        chk("ill_err", err, 1);
        pulse_tx_done();
        repeat (3) tick();
        chk("err_sticky", err, 1);

        // calibration timeout
        send_cmd(16'h0000);
        chk("cal_go", cal_go, 1);
        n = 0;
        while (n < 40 && trmt !== 1'b1) begin
            tick();
            n++;
        end
        chk("tmo_latency", n, 15);
        chk("tmo_nak", tx_data, 8'hEE);
        pulse_tx_done();

        // done coincident with saturation
        send_cmd(16'h0000);
        repeat (14) tick();
        pulse_done(0);
        chk("tie_trmt", trmt, 1);
        chk("tie_ack", tx_data, 8'hA5);
        pulse_tx_done();

        // telemetry held off during a move
        send_cmd(16'h4001);
        tick();
        tlm_req = 1; tlm_data = 8'h3C;
        repeat (4) tick();
        chk("tlm_wait_gnt", tlm_gnt, 0);
        pulse_done(2);
        chk("tlm_ack_first", tx_data, 8'hA5);
        chk("tlm_ack_gnt", tlm_gnt, 0);
        pulse_tx_done();
        chk("tlm_idle_gnt", tlm_gnt, 0);
        tick();
        chk("tlm_gnt", tlm_gnt, 1);
        chk("tlm_trmt", trmt, 1);
        chk("tlm_byte", tx_data, 8'h3C);
        tlm_req = 0;
        pulse_tx_done();

        // command beats telemetry
        tlm_req = 1; tlm_data = 8'h55;
        send_cmd(16'h2010);
        chk("prio_clr", clr_cmd_rdy, 1);
        chk("prio_no_gnt", tlm_gnt, 0);
        pulse_done(1);
        pulse_tx_done();
        tick();
        chk("prio_late_gnt", tlm_gnt, 1);
        tlm_req = 0;
        pulse_tx_done();

        // reset during WAIT_HDG
        send_cmd(16'h2123);
        tick();
        #2 rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_err", err, 0);
        chk("arst_heading", heading, 0);
        chk("arst_tx", tx_data, 0);
        @(posedge clk); #1;
        rst_n = 1;
        pulse_done(1);
        repeat (10) begin
            tick();
            chk("arst_no_trmt", trmt, 0);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (i == 1000 || i == 2200) begin
                #3 rst_n = 0;
                cmd_rdy = 0; tlm_req = 0;
                @(posedge clk); #1;
                rst_n = 1;
            end
            if (clr_cmd_rdy) cmd_rdy = 0;
            else if (!cmd_rdy && $urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 4);
                op = (r == 0) ? 4'h0 : (r == 1) ? 4'h2 : (r == 2) ? 4'h4 : 4'($urandom);
                cmd = {op, 12'($urandom)};
                cmd_rdy = 1;
            end
            cal_done = ($urandom_range(0, 5) == 0);
            hdg_done = ($urandom_range(0, 5) == 0);
            mv_done  = ($urandom_range(0, 5) == 0);
            tx_done  = ($urandom_range(0, 3) == 0);
            if (tlm_gnt) tlm_req = 0;
            else if (!tlm_req && $urandom_range(0, 9) == 0) begin
                tlm_req = 1;
                tlm_data = 8'($urandom);
            end
        end
        tick();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
